// File: rtl/times5_pkg.sv
// Shared definitions for the times5 streaming kernel: default data width,
// the multiplier constant and the block-level control state encoding.
package times5_pkg;

    // Default width of the value channel on both streams.
    localparam int unsigned DATA_W_DEFAULT = 8;

    // Constant factor applied to every element.
    localparam int unsigned MULT_FACTOR = 5;

    // Block-level control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/times5_out_reg.sv
// One-entry output register for the times5 stream.
// Loads {value*MULT_FACTOR, last} on load_i; empties on accept_i when no new
// element arrives. Contents stay stable while held.
// Optional: define TIMES5_SATURATE_EN to clamp results that overflow DATA_W
// bits to all ones; otherwise the result wraps modulo 2^DATA_W.
module times5_out_reg
    import times5_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] value_i,
    input  logic              last_i,
    input  logic              accept_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] value_o,
    output logic              last_o
);

    logic              vld_q,   vld_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              last_q,  last_d;
    logic [DATA_W-1:0] result;

`ifdef TIMES5_SATURATE_EN
    // Three extra bits hold value*5 without loss for any DATA_W.
    localparam int unsigned EXT_W = DATA_W + 3;
    logic [EXT_W-1:0] prod_ext;

    // Full-precision product, clamped to all ones on overflow.
    always_comb begin
        prod_ext = {3'b000, value_i} * EXT_W'(MULT_FACTOR);
        if (|prod_ext[EXT_W-1:DATA_W]) begin
            result = '1;
        end else begin
            result = prod_ext[DATA_W-1:0];
        end
    end
`else
    localparam logic [DATA_W-1:0] MULT_W = DATA_W'(MULT_FACTOR);

    // Product truncated to DATA_W bits (modulo wrap).
    always_comb begin
        result = value_i * MULT_W;
    end
`endif

    // Next-state: a load has priority and refills; an accept alone empties.
    always_comb begin
        vld_d   = vld_q;
        value_d = value_q;
        last_d  = last_q;
        if (load_i) begin
            vld_d   = 1'b1;
            value_d = result;
            last_d  = last_i;
        end else if (accept_i) begin
            vld_d   = 1'b0;
        end
    end

    // Register update with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q   <= 1'b0;
            value_q <= '0;
            last_q  <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            value_q <= value_d;
            last_q  <= last_d;
        end
    end

    assign vld_o   = vld_q;
    assign value_o = value_q;
    assign last_o  = last_q;

endmodule

// File: rtl/times5_stream_top.sv
// Top-level accelerator wrapper: multiplies each input element by 5 and
// forwards it with its last flag. Block control via ap_start/ap_done/
// ap_idle/ap_ready; each stream channel uses a vld/ack handshake.
// Optional: define TIMES5_SATURATE_EN to saturate overflowing results.
module times5_stream_top
    import times5_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [DATA_W-1:0] hw_input_V_value_V,
    input  logic              hw_input_V_value_V_ap_vld,
    output logic              hw_input_V_value_V_ap_ack,
    input  logic              hw_input_V_last_V,
    input  logic              hw_input_V_last_V_ap_vld,
    output logic              hw_input_V_last_V_ap_ack,
    output logic [DATA_W-1:0] hw_output_V_value_V,
    output logic              hw_output_V_value_V_ap_vld,
    input  logic              hw_output_V_value_V_ap_ack,
    output logic              hw_output_V_last_V,
    output logic              hw_output_V_last_V_ap_vld,
    input  logic              hw_output_V_last_V_ap_ack
);

    state_t            state_q, state_d;
    logic              out_vld;
    logic [DATA_W-1:0] out_value;
    logic              out_last;
    logic              out_accept;
    logic              in_ack;

    // Handshake decode: a transfer needs both sink acks; input is consumed
    // only in RUN when both channels are valid and the register has room.
    always_comb begin
        out_accept = out_vld & hw_output_V_value_V_ap_ack
                             & hw_output_V_last_V_ap_ack;
        in_ack     = (state_q == RUN) & hw_input_V_value_V_ap_vld
                                      & hw_input_V_last_V_ap_vld
                                      & (~out_vld | out_accept);
    end

    // Control FSM next state: a last=1 element moves RUN to DRAIN; DRAIN
    // returns to IDLE once that element is taken downstream.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ap_start)                       state_d = RUN;
            RUN:     if (in_ack && hw_input_V_last_V)    state_d = DRAIN;
            DRAIN:   if (out_accept)                     state_d = IDLE;
            default:                                     state_d = IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Block status: done/ready pulse in the cycle the final element leaves.
    always_comb begin
        ap_idle  = (state_q == IDLE);
        ap_done  = (state_q == DRAIN) & out_accept;
        ap_ready = (state_q == DRAIN) & out_accept;
    end

    times5_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk_i    (ap_clk),
        .rst_i    (ap_rst),
        .load_i   (in_ack),
        .value_i  (hw_input_V_value_V),
        .last_i   (hw_input_V_last_V),
        .accept_i (out_accept),
        .vld_o    (out_vld),
        .value_o  (out_value),
        .last_o   (out_last)
    );

    assign hw_input_V_value_V_ap_ack  = in_ack;
    assign hw_input_V_last_V_ap_ack   = in_ack;
    assign hw_output_V_value_V        = out_value;
    assign hw_output_V_value_V_ap_vld = out_vld;
    assign hw_output_V_last_V         = out_last;
    assign hw_output_V_last_V_ap_vld  = out_vld;

endmodule

// File: tb/tb_times5_stream_top.sv
// Self-checking bench for times5_stream_top with a scoreboard of expected
// output elements. Honors TIMES5_SATURATE_EN in its reference model.
module tb_times5_stream_top;

    logic       ap_clk = 1'b0;
    logic       ap_rst;
    logic       ap_start;
    logic       ap_done, ap_idle, ap_ready;
    logic [7:0] in_val;
    logic       in_vvld, in_ack_v;
    logic       in_last;
    logic       in_lvld, in_ack_l;
    logic [7:0] out_val;
    logic       out_vvld, oack_v;
    logic       out_last;
    logic       out_lvld, oack_l;

    typedef struct packed {
        logic [7:0] v;
        logic       l;
    } item_t;

    item_t sb[$];
    int    acc_cyc[$];

    int n_vec = 0;
    int n_bad = 0;
    int n_inack = 0;
    int n_acc = 0;
    int n_done = 0;
    int cyc = 0;

    logic       exp_vld = 1'b0;
    logic       prev_hold = 1'b0;
    logic       prev_done = 1'b0;
    logic [7:0] prev_val = '0;
    logic       prev_last = 1'b0;

    times5_stream_top #(
        .DATA_W (8)
    ) dut (
        .ap_clk                     (ap_clk),
        .ap_rst                     (ap_rst),
        .ap_start                   (ap_start),
        .ap_done                    (ap_done),
        .ap_idle                    (ap_idle),
        .ap_ready                   (ap_ready),
        .hw_input_V_value_V         (in_val),
        .hw_input_V_value_V_ap_vld  (in_vvld),
        .hw_input_V_value_V_ap_ack  (in_ack_v),
        .hw_input_V_last_V          (in_last),
        .hw_input_V_last_V_ap_vld   (in_lvld),
        .hw_input_V_last_V_ap_ack   (in_ack_l),
        .hw_output_V_value_V        (out_val),
        .hw_output_V_value_V_ap_vld (out_vvld),
        .hw_output_V_value_V_ap_ack (oack_v),
        .hw_output_V_last_V         (out_last),
        .hw_output_V_last_V_ap_vld  (out_lvld),
        .hw_output_V_last_V_ap_ack  (oack_l)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc++;

    function automatic logic [7:0] exp5(input logic [7:0] v);
        int p;
        p = int'(v) * 5;
`ifdef TIMES5_SATURATE_EN
        if (p > 255) p = 255;
`endif
        return p[7:0];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard/monitor sampled on the falling edge.
    always @(negedge ap_clk) begin
        logic  acc;
        logic  exp_done;
        item_t e;
        if (ap_rst) begin
            sb.delete();
            exp_vld   = 1'b0;
            prev_hold = 1'b0;
            prev_done = 1'b0;
        end else begin
            acc      = out_vvld & oack_v & oack_l;
            exp_done = 1'b0;
            check_eq("out_vld", 32'(out_vvld), 32'(exp_vld));
            check_eq("last_vld_pair", 32'(out_lvld), 32'(out_vvld));
            check_eq("in_ack_pair", 32'(in_ack_l), 32'(in_ack_v));
            if (prev_hold) begin
                check_eq("hold_value", 32'(out_val), 32'(prev_val));
                check_eq("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (prev_done) check_eq("idle_after_done", 32'(ap_idle), 32'd1);
            if (acc) begin
                n_acc++;
                acc_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check_eq("out_value", 32'(out_val), 32'(e.v));
                    check_eq("out_last", 32'(out_last), 32'(e.l));
                    exp_done = e.l;
                end
            end
            check_eq("ap_done", 32'(ap_done), 32'(exp_done));
            check_eq("ap_ready", 32'(ap_ready), 32'(exp_done));
            if (in_ack_v) begin
                n_inack++;
                sb.push_back(item_t'{exp5(in_val), in_last});
            end
            if (in_ack_v)  exp_vld = 1'b1;
            else if (acc)  exp_vld = 1'b0;
            prev_hold = out_vvld & ~acc;
            prev_val  = out_val;
            prev_last = out_last;
            prev_done = ap_done;
            if (ap_done) n_done++;
        end
    end

    // All drivers enter and leave at 1 time unit after a rising edge.
    task automatic do_start();
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] v, input logic l);
        logic got;
        got     = 1'b0;
        in_val  = v;
        in_last = l;
        in_vvld = 1'b1;
        in_lvld = 1'b1;
        for (int unsigned i = 0; i < 200; i++) begin
            @(negedge ap_clk);
            if (in_ack_v) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge ap_clk); #1;
        in_vvld = 1'b0;
        in_lvld = 1'b0;
        check_eq("send_acked", 32'(got), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int unsigned budget);
        logic seen;
        seen = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge ap_clk);
            if (ap_done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq(tag, 32'(seen), 32'd1);
        @(posedge ap_clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_before;
        ap_rst   = 1'b1;
        ap_start = 1'b0;
        in_val   = '0;
        in_last  = 1'b0;
        in_vvld  = 1'b0;
        in_lvld  = 1'b0;
        oack_v   = 1'b0;
        oack_l   = 1'b0;

        // Reset state
        #1;
        check_eq("rst_idle", 32'(ap_idle), 32'd1);
        check_eq("rst_done", 32'(ap_done), 32'd0);
        check_eq("rst_ready", 32'(ap_ready), 32'd0);
        check_eq("rst_in_ack", 32'({in_ack_v, in_ack_l}), 32'd0);
        check_eq("rst_out_vld", 32'({out_vvld, out_lvld}), 32'd0);
        check_eq("rst_out_data", 32'({out_val, out_last}), 32'd0);
        repeat (2) @(posedge ap_clk);
        #1 ap_rst = 1'b0;

        // Idle with valid input but no start: nothing consumed
        in_vvld = 1'b1;
        in_lvld = 1'b1;
        repeat (3) begin
            @(negedge ap_clk);
            check_eq("idle_no_ack", 32'(in_ack_v), 32'd0);
            check_eq("idle_flag", 32'(ap_idle), 32'd1);
        end
        @(posedge ap_clk); #1;
        in_vvld = 1'b0;
        in_lvld = 1'b0;

        // Single element with sink always ready
        oack_v = 1'b1;
        oack_l = 1'b1;
        do_start();
        check_eq("run_not_idle", 32'(ap_idle), 32'd0);
        send(8'd7, 1'b1);
        wait_done("single_done", 20);

        // Back-to-back streaming including the wrap/saturate boundary
        acc_cyc.delete();
        do_start();
        send(8'd0, 1'b0);
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd51, 1'b0);
        send(8'd52, 1'b1);
        wait_done("stream_done", 20);
        check_eq("stream_count", 32'(acc_cyc.size()), 32'd5);
        if (acc_cyc.size() == 5)
            check_eq("stream_span", 32'(acc_cyc[4] - acc_cyc[0]), 32'd4);

        // Backpressure: sink stalled, then one-sided ack
        oack_v = 1'b0;
        oack_l = 1'b0;
        do_start();
        n_inack = 0;
        in_val  = 8'd9;
        in_last = 1'b0;
        in_vvld = 1'b1;
        in_lvld = 1'b1;
        repeat (10) @(negedge ap_clk);
        check_eq("bp_one_ack", 32'(n_inack), 32'd1);
        check_eq("bp_out_vld", 32'(out_vvld), 32'd1);
        @(posedge ap_clk); #1;
        in_vvld = 1'b0;
        in_lvld = 1'b0;
        oack_v  = 1'b1;
        acc_before = n_acc;
        repeat (2) @(negedge ap_clk);
        check_eq("one_sided_no_xfer", 32'(n_acc), 32'(acc_before));
        check_eq("one_sided_vld", 32'(out_vvld), 32'd1);
        @(posedge ap_clk); #1;
        oack_l = 1'b1;
        send(8'd4, 1'b1);
        wait_done("bp_done", 20);

        // Long stall: input held valid, sink never acks
        oack_v = 1'b0;
        oack_l = 1'b0;
        do_start();
        n_inack = 0;
        n_done  = 0;
        in_val  = 8'd100;
        in_last = 1'b0;
        in_vvld = 1'b1;
        in_lvld = 1'b1;
        repeat (500) @(negedge ap_clk);
        check_eq("stall_one_ack", 32'(n_inack), 32'd1);
        check_eq("stall_no_done", 32'(n_done), 32'd0);

        // Asynchronous reset mid-frame with a full output register
        @(posedge ap_clk); #1;
        check_eq("pre_rst_vld", 32'(out_vvld), 32'd1);
        ap_rst = 1'b1;
        #1;
        check_eq("arst_out_vld", 32'(out_vvld), 32'd0);
        check_eq("arst_idle", 32'(ap_idle), 32'd1);
        check_eq("arst_out_data", 32'({out_val, out_last}), 32'd0);
        check_eq("arst_in_ack", 32'(in_ack_v), 32'd0);
        in_vvld = 1'b0;
        in_lvld = 1'b0;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        oack_v = 1'b1;
        oack_l = 1'b1;
        do_start();
        send(8'd3, 1'b1);
        wait_done("post_rst_done", 20);

        repeat (2) @(posedge ap_clk);
        #1;
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
